// File: rtl/parking_gate_arbiter_if.sv
// Signal bundle between the car-park lane sensors/password checker and the
// shared-gate arbiter. The master side drives the sensor inputs, the slave owns the gate.
interface parking_gate_arbiter_if #(
    parameter int CNT_W = 4
);
    // Handshake: entry_req/exit_req are levels held by a waiting car until served;
    // pass_ok and car_through are only acted upon in the state that expects them,
    // and every output is registered, so no request reaches an output in the same cycle.
    logic             entry_req;
    logic             exit_req;
    logic             pass_ok;
    logic             car_through;
    logic             entry_gnt;
    logic             exit_gnt;
    logic             gate_open;
    logic             timeout_err;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W-1:0] free_spaces;
    logic [2:0]       state_dbg;

    modport master (
        output entry_req, exit_req, pass_ok, car_through,
        input  entry_gnt, exit_gnt, gate_open, timeout_err,
        input  full, empty, occupancy, free_spaces, state_dbg
    );

    modport slave (
        input  entry_req, exit_req, pass_ok, car_through,
        output entry_gnt, exit_gnt, gate_open, timeout_err,
        output full, empty, occupancy, free_spaces, state_dbg
    );
endinterface

// File: rtl/parking_gate_arbiter.sv
// Shared-barrier arbiter: alternates the single gate between entry and exit
// lanes, waits for password authorisation, and keeps a saturating occupancy count.
module parking_gate_arbiter #(
    parameter int CAPACITY = 8,
    parameter int CNT_W    = 4,
    parameter int TIMEOUT  = 16,
    parameter int TO_W     = 5
) (
    input  logic                  clock_in,
    input  logic                  rst_in,
    parking_gate_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        AUTH       = 3'd1,
        OPEN_ENTRY = 3'd2,
        OPEN_EXIT  = 3'd3,
        CLOSE      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CAP       = CNT_W'(CAPACITY);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic             LANE_ENTRY = 1'b0;
    localparam logic             LANE_EXIT  = 1'b1;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] occ;
    logic [CNT_W-1:0] occ_nx;
    logic [TO_W-1:0]  timer;
    logic [TO_W-1:0]  timer_nx;
    logic             last_served;
    logic             last_nx;
    logic             err_q;
    logic             err_nx;

    logic full_w;
    logic empty_w;
    logic entry_v;
    logic exit_v;
    logic timer_hit;

    assign full_w    = (occ == CAP);
    assign empty_w   = (occ == '0);
    assign entry_v   = bus.entry_req && !full_w;
    assign exit_v    = bus.exit_req && !empty_w;
    assign timer_hit = (timer == TO_LAST);

    always_comb begin
        state_nx = state;
        occ_nx   = occ;
        last_nx  = last_served;
        err_nx   = 1'b0;
        timer_nx = '0;

        case (state)
            IDLE: begin
                // On a tie the lane that was not served most recently wins.
                if (entry_v && exit_v) begin
                    state_nx = (last_served == LANE_EXIT) ? AUTH : OPEN_EXIT;
                end else if (entry_v) begin
                    state_nx = AUTH;
                end else if (exit_v) begin
                    state_nx = OPEN_EXIT;
                end
            end

            AUTH: begin
                if (bus.pass_ok) begin
                    state_nx = OPEN_ENTRY;
                    last_nx  = LANE_ENTRY;
                end else if (!bus.entry_req) begin
                    state_nx = CLOSE;
                    last_nx  = LANE_ENTRY;
                end else if (timer_hit) begin
                    state_nx = CLOSE;
                    last_nx  = LANE_ENTRY;
                    err_nx   = 1'b1;
                end
            end

            OPEN_ENTRY: begin
                if (bus.car_through) begin
                    state_nx = CLOSE;
                    last_nx  = LANE_ENTRY;
                    if (occ != CAP) begin
                        occ_nx = occ + CNT_W'(1);
                    end
                end else if (timer_hit) begin
                    state_nx = CLOSE;
                    last_nx  = LANE_ENTRY;
                    err_nx   = 1'b1;
                end
            end

            OPEN_EXIT: begin
                if (bus.car_through) begin
                    state_nx = CLOSE;
                    last_nx  = LANE_EXIT;
                    if (occ != '0) begin
                        occ_nx = occ - CNT_W'(1);
                    end
                end else if (timer_hit) begin
                    state_nx = CLOSE;
                    last_nx  = LANE_EXIT;
                    err_nx   = 1'b1;
                end
            end

            CLOSE: begin
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase

        // The timer only runs while a lane holds the gate; any move restarts it.
        if (state_nx != state) begin
            timer_nx = '0;
        end else if (state == AUTH || state == OPEN_ENTRY || state == OPEN_EXIT) begin
            timer_nx = timer + TO_W'(1);
        end
    end

    always_ff @(posedge clock_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= IDLE;
            occ         <= '0;
            timer       <= '0;
            last_served <= LANE_EXIT;
            err_q       <= 1'b0;
        end else begin
            state       <= state_nx;
            occ         <= occ_nx;
            timer       <= timer_nx;
            last_served <= last_nx;
            err_q       <= err_nx;
        end
    end

    assign bus.entry_gnt   = (state == AUTH) || (state == OPEN_ENTRY);
    assign bus.exit_gnt    = (state == OPEN_EXIT);
    assign bus.gate_open   = (state == OPEN_ENTRY) || (state == OPEN_EXIT);
    assign bus.timeout_err = err_q;
    assign bus.full        = full_w;
    assign bus.empty       = empty_w;
    assign bus.occupancy   = occ;
    assign bus.free_spaces = CAP - occ;
    assign bus.state_dbg   = state;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Bench for parking_gate_arbiter: vector table, directed corner sequences and
// random traffic, all checked against a lane/gate reference model.
module tb_parking_gate_arbiter;
  localparam int CAP = 8;
  localparam int TO  = 16;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  parking_gate_arbiter_if #(.CNT_W(4)) bus ();

  parking_gate_arbiter #(
    .CAPACITY(CAP), .CNT_W(4), .TIMEOUT(TO), .TO_W(5)
  ) dut (
    .clock_in(clk),
    .rst_in(rst),
    .bus(bus)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // reference model: who holds the gate, whether it is raised, how long
  int m_occ;
  int m_age;
  int m_user;        // 0 nobody, 1 entry lane, 2 exit lane
  bit m_raised;
  bit m_cool;        // the one mandatory gate-down cycle between users
  bit m_err;
  bit m_last_entry;

  task automatic model_reset();
    m_occ = 0; m_age = 0; m_user = 0;
    m_raised = 0; m_cool = 0; m_err = 0; m_last_entry = 0;
  endtask

  task automatic model_step(input logic e, input logic x, input logic p, input logic t);
    bit fin, to, ev, xv;
    fin = 0; to = 0;
    m_err = 0;
    if (m_cool) begin
      m_cool = 0;
    end else if (m_user == 0) begin
      ev = e && (m_occ < CAP);
      xv = x && (m_occ > 0);
      if (ev && (!xv || !m_last_entry)) begin
        m_user = 1; m_raised = 0; m_age = 0;
      end else if (xv) begin
        m_user = 2; m_raised = 1; m_age = 0;
      end
    end else if (m_user == 1 && !m_raised) begin
      if (p) begin
        m_raised = 1; m_age = 0; m_last_entry = 1;
      end else if (!e) fin = 1;
      else if (m_age == TO - 1) begin fin = 1; to = 1; end
      else m_age++;
    end else begin
      if (t) begin
        if (m_user == 1) m_occ = (m_occ < CAP) ? m_occ + 1 : m_occ;
        else             m_occ = (m_occ > 0) ? m_occ - 1 : 0;
        fin = 1;
      end else if (m_age == TO - 1) begin fin = 1; to = 1; end
      else m_age++;
    end
    if (fin) begin
      m_last_entry = (m_user == 1);
      m_user = 0; m_raised = 0; m_cool = 1; m_err = to;
    end
  endtask

  function automatic logic [13:0] exp_vec(input logic ge, input logic gx, input logic op,
                                          input logic er, input int occ);
    logic [3:0] o, f;
    o = 4'(occ);
    f = 4'(CAP - occ);
    return {ge, gx, op, er, (occ == CAP), (occ == 0), o, f};
  endfunction

  function automatic logic [13:0] act_vec();
    return {bus.entry_gnt, bus.exit_gnt, bus.gate_open, bus.timeout_err,
            bus.full, bus.empty, bus.occupancy, bus.free_spaces};
  endfunction

  function automatic logic [13:0] model_vec();
    return exp_vec(m_user == 1, m_user == 2, m_raised, m_err, m_occ);
  endfunction

  // scoreboard
  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic cycle(input logic e, input logic x, input logic p, input logic t);
    @(negedge clk);
    bus.entry_req = e; bus.exit_req = x; bus.pass_ok = p; bus.car_through = t;
    model_step(e, x, p, t);
    @(posedge clk);
    #1;
    check("model", act_vec(), model_vec());
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    bus.entry_req = 0; bus.exit_req = 0; bus.pass_ok = 0; bus.car_through = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_values", act_vec(), exp_vec(0, 0, 0, 0, 0));
  endtask

  task automatic do_entry();
    cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
  endtask

  task automatic do_exit();
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
  endtask

  task automatic timeout_run(input bit use_exit, input string name);
    int n;
    int occ0;
    occ0 = m_occ;
    n = 0;
    cycle(!use_exit, use_exit, 0, 0);
    while ((bus.entry_gnt || bus.exit_gnt) && n < 40) begin
      n++;
      cycle(!use_exit, use_exit, 0, 0);
    end
    check({name, "_cycles"}, 14'(n), 14'(TO));
    check({name, "_err"}, 14'(bus.timeout_err), 14'(1));
    check({name, "_occ"}, 14'(bus.occupancy), 14'(occ0));
    cycle(0, 0, 0, 0);
    check({name, "_err_clear"}, 14'(bus.timeout_err), 14'(0));
  endtask

  typedef struct packed {
    logic [3:0] stim;   // entry_req, exit_req, pass_ok, car_through
    logic [3:0] outs;   // entry_gnt, exit_gnt, gate_open, timeout_err
    logic [3:0] occ;
  } vec_t;

  vec_t tbl [14];

  initial begin
    rst = 1'b0;
    bus.entry_req = 0; bus.exit_req = 0; bus.pass_ok = 0; bus.car_through = 0;
    model_reset();

    tbl[0]  = {4'b1000, 4'b1000, 4'd0};
    tbl[1]  = {4'b1000, 4'b1000, 4'd0};
    tbl[2]  = {4'b1000, 4'b1000, 4'd0};
    tbl[3]  = {4'b1010, 4'b1010, 4'd0};
    tbl[4]  = {4'b0000, 4'b1010, 4'd0};
    tbl[5]  = {4'b0001, 4'b0000, 4'd1};
    tbl[6]  = {4'b0000, 4'b0000, 4'd1};
    tbl[7]  = {4'b0100, 4'b0110, 4'd1};
    tbl[8]  = {4'b0101, 4'b0000, 4'd0};
    tbl[9]  = {4'b0100, 4'b0000, 4'd0};
    tbl[10] = {4'b0001, 4'b0000, 4'd0};
    tbl[11] = {4'b1000, 4'b1000, 4'd0};
    tbl[12] = {4'b0000, 4'b0000, 4'd0};
    tbl[13] = {4'b0000, 4'b0000, 4'd0};

    reset_dut();

    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].stim[3], tbl[i].stim[2], tbl[i].stim[1], tbl[i].stim[0]);
      check($sformatf("table_%0d", i), act_vec(),
            exp_vec(tbl[i].outs[3], tbl[i].outs[2], tbl[i].outs[1], tbl[i].outs[0],
                    int'(tbl[i].occ)));
    end

    timeout_run(0, "auth_timeout");
    do_entry();
    timeout_run(1, "exit_timeout");

    // round-robin on simultaneous requests
    reset_dut();
    repeat (3) do_entry();
    do_exit();
    cycle(1, 1, 0, 0);
    check("rr_first_entry", 14'({bus.entry_gnt, bus.exit_gnt}), 14'(2'b10));
    cycle(1, 1, 1, 0);
    cycle(0, 0, 0, 1);
    check("rr_occ_3", 14'(bus.occupancy), 14'(3));
    cycle(0, 0, 0, 0);
    cycle(1, 1, 0, 0);
    check("rr_then_exit", 14'({bus.entry_gnt, bus.exit_gnt}), 14'(2'b01));
    cycle(1, 1, 0, 1);
    check("rr_occ_2", 14'(bus.occupancy), 14'(2));
    cycle(0, 0, 0, 0);
    cycle(1, 1, 0, 0);
    check("rr_entry_again", 14'({bus.entry_gnt, bus.exit_gnt}), 14'(2'b10));
    cycle(1, 1, 1, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    check("rr_occ_final", 14'(bus.occupancy), 14'(3));

    // full lot blocks entry, exit still served
    repeat (5) do_entry();
    check("full_flag", 14'({bus.full, bus.empty}), 14'(2'b10));
    cycle(1, 0, 0, 0);
    check("full_entry_blocked", 14'(bus.entry_gnt), 14'(0));
    cycle(1, 1, 0, 0);
    check("full_exit_granted", 14'({bus.entry_gnt, bus.exit_gnt}), 14'(2'b01));
    cycle(1, 1, 0, 1);
    check("full_dropped", 14'({bus.full, bus.occupancy}), 14'({1'b0, 4'd7}));
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    check("after_full_entry", 14'({bus.entry_gnt, bus.exit_gnt}), 14'(2'b10));
    cycle(1, 0, 1, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);

    // reset asserted while a car is passing the open entry gate
    reset_dut();
    repeat (5) do_entry();
    cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 0);
    check("pre_reset_open", 14'({bus.gate_open, bus.occupancy}), 14'({1'b1, 4'd5}));
    @(negedge clk);
    bus.car_through = 1'b1;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_reset_now", act_vec(), exp_vec(0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("reset_ignores_thru", act_vec(), exp_vec(0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    bus.car_through = 1'b0;
    bus.entry_req = 1'b0;
    bus.pass_ok = 1'b0;
    cycle(0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 25);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/parking_gate_arbiter.md
# parking_gate_arbiter

Shared-barrier controller for a single-lane car park where entering and leaving cars use one physical gate. It arbitrates between the entry and exit lanes and holds an entry grant until the password checker authorises the car. It opens the gate, tracks lot occupancy against a fixed capacity, and closes the gate on a car-through event or a timeout. It sits above the per-lane password/LED FSM and owns the barrier and the occupancy count.

## Interface
- CAPACITY, 8: number of parking spaces (1..2^CNT_W-1).
- CNT_W, 4: width of occupancy/free-space counters.
- TIMEOUT, 16: cycles allowed in any waiting/open state before forced close (>=2).
- TO_W, 5: width of timeout counter (must hold TIMEOUT-1).
- clock_in  input  1  system clock, all state updates on rising edge.
- rst_in  input  1  reset; asynchronous, active-high.
- entry_req  input  1  car present at entry front sensor (level).
- exit_req  input  1  car present at exit sensor (level).
- pass_ok  input  1  password checker reports correct password for the entry car (level or pulse).
- car_through  input  1  barrier sensor pulse: car has passed the gate.
- entry_gnt  output  1  entry lane owns the gate (AUTH or OPEN_ENTRY).
- exit_gnt  output  1  exit lane owns the gate (OPEN_EXIT).
- gate_open  output  1  barrier raise command.
- timeout_err  output  1  one-cycle flag: previous grant ended by timeout.
- full  output  1  occupancy == CAPACITY.
- empty  output  1  occupancy == 0.
- occupancy  output  CNT_W  cars currently in lot.
- free_spaces  output  CNT_W  CAPACITY - occupancy.

## Operation
- States: IDLE, AUTH, OPEN_ENTRY, OPEN_EXIT, CLOSE. All outputs Moore-decoded from registered state/counters; no input-to-output combinational path.
- Request validity: entry_v = entry_req && !full; exit_v = exit_req && !empty.
- IDLE: if only entry_v -> AUTH; only exit_v -> OPEN_EXIT; both -> lane not served last (last_served register; reset value = exit, so entry wins first tie); neither -> stay.
- AUTH: pass_ok -> OPEN_ENTRY; else entry_req low -> CLOSE (abandon, no error); else timer == TIMEOUT-1 -> CLOSE with error.
- OPEN_ENTRY: car_through -> occupancy+1, -> CLOSE; else timer == TIMEOUT-1 -> CLOSE with error, occupancy unchanged.
- OPEN_EXIT: car_through -> occupancy-1, -> CLOSE; else timeout as above.
- CLOSE: exactly one cycle, gate_open=0, both grants 0; -> IDLE. Guarantees the barrier drops between consecutive users.
- last_served updates on leaving AUTH/OPEN_ENTRY (entry) or OPEN_EXIT (exit), regardless of success.
- Timer clears on every state transition and increments each cycle in AUTH/OPEN_*. Precedence within a cycle: car_through/pass_ok > entry_req drop > timeout.
- Occupancy saturates: never exceeds CAPACITY or underflows; car_through ignored outside OPEN_*.
- timeout_err is registered, high only during the CLOSE cycle that follows a timeout.

## Timing
- Reset (async, immediate): state=IDLE, occupancy=0, timer=0, last_served=exit, timeout_err=0; hence gate_open=0, entry_gnt=0, exit_gnt=0, full=0, empty=1, free_spaces=CAPACITY.
- Request sampled at edge k in IDLE -> grant high from edge k.
- pass_ok sampled at edge k in AUTH -> gate_open high from edge k.
- car_through at edge k -> occupancy updated, gate_open low from edge k; IDLE at k+1; next grant at earliest k+2.
- Timeout: grant ends at the edge where timer==TIMEOUT-1 is sampled, i.e. TIMEOUT cycles after state entry.
- Reset asserted mid-grant: gate drops and occupancy clears at once; no partial count update.

## Test plan
- Reset: assert rst_in for 3 cycles with inputs idle -> all outputs at reset values, free_spaces=8, empty=1.
- Entry flow: entry_req=1, pass_ok after 3 cycles, car_through 2 cycles later -> entry_gnt 1 cycle after req, gate_open 1 cycle after pass_ok, occupancy=1, gate_open=0 for CLOSE, back to IDLE.
- Tie round-robin: entry_req and exit_req held with occupancy=2 -> entry served first, then exit, then entry again; occupancy 2->3->2->3.
- Full: fill to 8, hold entry_req and exit_req -> entry never granted, exit granted, occupancy 7, full drops, then entry granted.
- Timeout: entry_req held, no pass_ok -> CLOSE after 16 cycles in AUTH, timeout_err high 1 cycle, occupancy unchanged; same for OPEN_EXIT without car_through.
- Reset mid-operation: rst_in asserted while OPEN_ENTRY with occupancy=5 -> gate_open=0 and occupancy=0 immediately; car_through in same cycle is not counted.
